// File: rtl/iomem_gpio_pwm.sv
// iomem GPIO/PWM peripheral: NUM_CH pads, each either a static GPIO bit or a prescaled, double-buffered PWM.
// Latency: acknowledge and read data one cycle after a selected request; pins registered one cycle behind the counter.
// Backpressure: none; a held request is acknowledged every other cycle and the master drops valid after ready.
module iomem_gpio_pwm #(
  parameter int         NUM_CH        = 3,
  parameter int         PWM_BITS      = 8,
  parameter int         PRESCALE_BITS = 16,
  parameter logic [7:0] BASE_ADDR     = 8'h03
) (
  input  logic              clk_20M,
  input  logic              resetn,
  input  logic              iomem_valid,
  output logic              iomem_ready,
  input  logic [3:0]        iomem_wstrb,
  input  logic [31:0]       iomem_addr,
  input  logic [31:0]       iomem_wdata,
  output logic [31:0]       iomem_rdata,
  output logic [NUM_CH-1:0] pin_o,
  output logic              irq_o
);

  localparam logic [PWM_BITS-1:0] CNT_MAX = {PWM_BITS{1'b1}};

  logic                     ready_q, ready_d;
  logic [31:0]              rdata_q, rdata_d;
  logic [31:0]              out_q, out_d;
  logic [NUM_CH-1:0]        mode_q, mode_d;
  logic [NUM_CH-1:0]        pin_q, pin_d;
  logic [PRESCALE_BITS-1:0] prescale_q, prescale_d;
  logic [PRESCALE_BITS-1:0] psc_q, psc_d;
  logic [1:0]               ctrl_q, ctrl_d;
  logic                     wrap_q, wrap_d;
  logic [PWM_BITS-1:0]      cnt_q, cnt_d;
  logic [PWM_BITS-1:0]      duty_sh_q  [NUM_CH];
  logic [PWM_BITS-1:0]      duty_sh_d  [NUM_CH];
  logic [PWM_BITS-1:0]      duty_act_q [NUM_CH];
  logic [PWM_BITS-1:0]      duty_act_d [NUM_CH];

  logic        sel, acc, wr_en, rd_en, tick, wrap_evt;
  logic [5:0]  reg_idx;
  logic [31:0] wmask, rd_val;
  logic        unused_addr;

  // Byte-lane merge: lanes with a strobe take the write data, the rest keep the old value.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wdat,
                                        input logic [31:0] msk);
    return (old & ~msk) | (wdat & msk);
  endfunction

  assign sel      = iomem_valid && (iomem_addr[31:24] == BASE_ADDR);
  assign acc      = sel && !ready_q;
  assign wr_en    = acc && (iomem_wstrb != 4'd0);
  assign rd_en    = acc && (iomem_wstrb == 4'd0);
  assign reg_idx  = iomem_addr[7:2];
  assign wmask    = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}}, {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
  // Middle and byte-offset address bits are not decoded.
  assign unused_addr = ^{iomem_addr[23:8], iomem_addr[1:0]};

  // Prescaler tick; >= keeps a shrunk reload from letting the prescaler run away.
  assign tick     = ctrl_q[0] && (psc_q >= prescale_q);
  assign wrap_evt = tick && (cnt_q == CNT_MAX);

  // Register-file writes; unmapped offsets and absent channels fall through untouched.
  always_comb begin
    out_d      = out_q;
    mode_d     = mode_q;
    prescale_d = prescale_q;
    ctrl_d     = ctrl_q;
    duty_sh_d  = duty_sh_q;
    if (wr_en) begin
      case (reg_idx)
        6'd0: out_d      = merge(out_q, iomem_wdata, wmask);
        6'd1: mode_d     = NUM_CH'(merge(32'(mode_q), iomem_wdata, wmask));
        6'd2: prescale_d = PRESCALE_BITS'(merge(32'(prescale_q), iomem_wdata, wmask));
        6'd3: ctrl_d     = 2'(merge(32'(ctrl_q), iomem_wdata, wmask));
        default: begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (reg_idx == 6'(8 + i)) begin
              duty_sh_d[i] = PWM_BITS'(merge(32'(duty_sh_q[i]), iomem_wdata, wmask));
            end
          end
        end
      endcase
    end
  end

  // Read mux and handshake; read data is only non-zero alongside ready.
  always_comb begin
    rd_val = '0;
    case (reg_idx)
      6'd0: rd_val = out_q;
      6'd1: rd_val = 32'(mode_q);
      6'd2: rd_val = 32'(prescale_q);
      6'd3: rd_val = 32'(ctrl_q);
      6'd4: rd_val = 32'(wrap_q);
      default: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (reg_idx == 6'(8 + i)) rd_val = 32'(duty_sh_q[i]);
        end
      end
    endcase
    ready_d = sel && !ready_q;
    rdata_d = rd_en ? rd_val : '0;
  end

  // Counters, duty reload on wrap, sticky wrap flag (set beats clear) and pin levels.
  always_comb begin
    psc_d      = ctrl_q[0] ? (tick ? '0 : psc_q + 1'b1) : '0;
    cnt_d      = ctrl_q[0] ? (tick ? cnt_q + 1'b1 : cnt_q) : '0;
    wrap_d     = wrap_q;
    duty_act_d = duty_act_q;
    pin_d      = '0;
    if (wr_en && (reg_idx == 6'd4) && iomem_wstrb[0] && iomem_wdata[0]) wrap_d = 1'b0;
    if (wrap_evt) begin
      wrap_d     = 1'b1;
      duty_act_d = duty_sh_q;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      pin_d[i] = mode_q[i] ? (ctrl_q[0] && (cnt_q < duty_act_q[i])) : out_q[i];
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_20M) begin
    if (!resetn) begin
      ready_q    <= 1'b0;
      rdata_q    <= '0;
      out_q      <= '0;
      mode_q     <= '0;
      pin_q      <= '0;
      prescale_q <= '0;
      psc_q      <= '0;
      ctrl_q     <= '0;
      wrap_q     <= 1'b0;
      cnt_q      <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        duty_sh_q[i]  <= '0;
        duty_act_q[i] <= '0;
      end
    end else begin
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
      out_q      <= out_d;
      mode_q     <= mode_d;
      pin_q      <= pin_d;
      prescale_q <= prescale_d;
      psc_q      <= psc_d;
      ctrl_q     <= ctrl_d;
      wrap_q     <= wrap_d;
      cnt_q      <= cnt_d;
      duty_sh_q  <= duty_sh_d;
      duty_act_q <= duty_act_d;
    end
  end

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign pin_o       = pin_q;
  assign irq_o       = wrap_q & ctrl_q[1];

endmodule

// File: tb/tb_iomem_gpio_pwm.sv
// Bench for iomem_gpio_pwm: random and directed bus traffic against a cycle model.
// Model predicts ready/rdata/pins/irq each edge into a queue; a negedge monitor pops and compares.
// Directed checks measure PWM high time per period, wrap/W1C collision and mid-period reset.
module tb_iomem_gpio_pwm;
  localparam int         NUM_CH = 3;
  localparam int         PWM_BITS = 8;
  localparam int         PERIOD = 1 << PWM_BITS;
  localparam logic [7:0] BASE = 8'h03;

  logic              clk_20M = 1'b0;
  logic              resetn = 1'b0;
  logic              iomem_valid = 1'b0;
  logic              iomem_ready;
  logic [3:0]        iomem_wstrb = '0;
  logic [31:0]       iomem_addr = '0;
  logic [31:0]       iomem_wdata = '0;
  logic [31:0]       iomem_rdata;
  logic [NUM_CH-1:0] pin_o;
  logic              irq_o;

  iomem_gpio_pwm #(.NUM_CH(NUM_CH), .PWM_BITS(PWM_BITS), .PRESCALE_BITS(16), .BASE_ADDR(BASE)) dut (
    .clk_20M(clk_20M), .resetn(resetn), .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata),
    .iomem_rdata(iomem_rdata), .pin_o(pin_o), .irq_o(irq_o));

  always #25 clk_20M = ~clk_20M;

  int n_cmp = 0;
  int n_err = 0;
  int n_cyc = 0;

  typedef struct packed {
    logic              ready;
    logic [31:0]       rdata;
    logic [NUM_CH-1:0] pin;
    logic              irq;
  } exp_t;
  exp_t exp_q[$];

  // ---------------- reference model ----------------
  logic [31:0]       m_out, m_mode, m_pre, m_ctrl, m_wrap, m_rdata, m_rv, m_msk;
  logic [31:0]       m_sh [NUM_CH];
  logic [31:0]       m_act [NUM_CH];
  logic              m_ready, m_sel, m_acc, m_tick, m_wrapev;
  logic [NUM_CH-1:0] m_pin, m_pin_n;
  int                en_cycles, n_ticks, wrap_cnt, m_idx, m_cnt;

  function automatic logic [31:0] read_reg(input int idx);
    if (idx == 0) return m_out;
    if (idx == 1) return m_mode;
    if (idx == 2) return m_pre;
    if (idx == 3) return m_ctrl;
    if (idx == 4) return m_wrap;
    if (idx >= 8 && idx < 8 + NUM_CH) return m_sh[idx-8];
    return 32'd0;
  endfunction

  always @(posedge clk_20M) begin
    n_cyc++;
    if (!resetn) begin
      m_out = 0; m_mode = 0; m_pre = 0; m_ctrl = 0; m_wrap = 0; m_rdata = 0;
      for (int i = 0; i < NUM_CH; i++) begin m_sh[i] = 0; m_act[i] = 0; end
      m_ready = 0; m_pin = 0; en_cycles = 0; n_ticks = 0;
    end else begin
      m_sel = iomem_valid && (iomem_addr[31:24] == BASE);
      m_acc = m_sel && !m_ready;
      m_idx = int'(iomem_addr[7:2]);
      m_rv  = read_reg(m_idx);
      // time since enable: tick every (PRESCALE+1) cycles, counter = ticks mod period
      m_cnt    = n_ticks % PERIOD;
      m_tick   = m_ctrl[0] && ((en_cycles % (int'(m_pre) + 1)) == int'(m_pre));
      m_wrapev = m_tick && (m_cnt == PERIOD - 1);
      for (int i = 0; i < NUM_CH; i++)
        m_pin_n[i] = m_mode[i] ? (m_ctrl[0] && (m_cnt < int'(m_act[i]))) : m_out[i];
      if (m_ctrl[0]) begin en_cycles++; if (m_tick) n_ticks++; end
      else begin en_cycles = 0; n_ticks = 0; end
      if (m_wrapev) begin
        for (int i = 0; i < NUM_CH; i++) m_act[i] = m_sh[i];
        wrap_cnt++;
      end
      if (m_acc && iomem_wstrb != 0) begin
        for (int b = 0; b < 4; b++) m_msk[8*b +: 8] = {8{iomem_wstrb[b]}};
        case (m_idx)
          0: m_out  = (m_out  & ~m_msk) | (iomem_wdata & m_msk);
          1: m_mode = ((m_mode & ~m_msk) | (iomem_wdata & m_msk)) & ((32'd1 << NUM_CH) - 1);
          2: m_pre  = ((m_pre  & ~m_msk) | (iomem_wdata & m_msk)) & 32'hFFFF;
          3: m_ctrl = ((m_ctrl & ~m_msk) | (iomem_wdata & m_msk)) & 32'h3;
          4: if (iomem_wstrb[0] && iomem_wdata[0]) m_wrap = 0;
          default: if (m_idx >= 8 && m_idx < 8 + NUM_CH)
            m_sh[m_idx-8] = ((m_sh[m_idx-8] & ~m_msk) | (iomem_wdata & m_msk)) & (PERIOD - 1);
        endcase
      end
      if (m_wrapev) m_wrap = 1;
      m_rdata = (m_acc && iomem_wstrb == 0) ? m_rv : 32'd0;
      m_ready = m_sel && !m_ready;
      m_pin   = m_pin_n;
    end
    exp_q.push_back({m_ready, m_rdata, m_pin, m_wrap[0] & m_ctrl[1]});
  end

  // ---------------- monitor ----------------
  always @(negedge clk_20M) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if ({iomem_ready, iomem_rdata, pin_o, irq_o} !== e) begin
        n_err++;
        $display("FAIL outputs cyc%0d: got ready=%0b rdata=%08h pin=%b irq=%0b, required ready=%0b rdata=%08h pin=%b irq=%0b",
                 n_cyc, iomem_ready, iomem_rdata, pin_o, irq_o, e.ready, e.rdata, e.pin, e.irq);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, got, want);
    end
  endtask

  // Caller is at a negedge; returns at the negedge where ready was seen.
  task automatic bus(input logic [7:0] base, input logic [7:0] off, input logic [3:0] ws,
                     input logic [31:0] wd, output logic [31:0] rd);
    int t;
    rd = '0;
    iomem_valid = 1'b1;
    iomem_addr  = {base, 16'($urandom), off[7:2], 2'($urandom)};
    iomem_wstrb = ws;
    iomem_wdata = wd;
    if (base != BASE) begin
      repeat (3) @(negedge clk_20M);
    end else begin
      t = 0;
      do begin @(negedge clk_20M); t++; end while (!iomem_ready && t < 8);
      if (!iomem_ready) chk("bus_timeout", 32'd0, 32'd1);
      rd = iomem_rdata;
    end
    iomem_valid = 1'b0;
    iomem_wstrb = '0;
  endtask

  task automatic wait_wrap();
    int w0, t;
    w0 = wrap_cnt; t = 0;
    while (wrap_cnt == w0 && t < 2000) begin @(negedge clk_20M); t++; end
    if (wrap_cnt == w0) chk("wrap_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_cnt_max();
    int t;
    t = 0;
    while (!(m_ctrl[0] && (n_ticks % PERIOD) == PERIOD - 1) && t < 2000) begin @(negedge clk_20M); t++; end
    if (t >= 2000) chk("cnt_max_timeout", 32'd0, 32'd1);
  endtask

  // Counts pin_o[0] over one full period window; caller is just after a wrap edge.
  task automatic count_period(output int hi, output int rises);
    logic prev;
    hi = 0; rises = 0; prev = pin_o[0];
    repeat (PERIOD) begin
      @(negedge clk_20M);
      if (pin_o[0] && !prev) rises++;
      if (pin_o[0]) hi++;
      prev = pin_o[0];
    end
  endtask

  initial begin
    #(50 * 60000);
    $display("FAIL global_timeout: simulation did not finish");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rd;
    logic [7:0]  off, base;
    logic [5:0]  ix;
    logic [3:0]  ws;
    int          hi, rises, pulses;
    logic [7:0]  offs [10] = '{8'h00, 8'h04, 8'h0C, 8'h10, 8'h14, 8'h20, 8'h24, 8'h28, 8'h2C, 8'h3C};

    repeat (3) @(negedge clk_20M);
    chk("rst_ready", 32'(iomem_ready), 0);
    chk("rst_rdata", iomem_rdata, 0);
    chk("rst_pin", 32'(pin_o), 0);
    chk("rst_irq", 32'(irq_o), 0);
    resetn = 1'b1;
    @(negedge clk_20M);

    // GPIO write and readback
    bus(BASE, 8'h00, 4'b0001, 32'h5, rd);
    @(negedge clk_20M);
    chk("gpio_pin", 32'(pin_o), 32'h5);
    bus(BASE, 8'h00, 4'b0000, 32'h0, rd);
    chk("gpio_read", rd, 32'h5);

    // PWM duty 64 on channel 0, prescale 0
    bus(BASE, 8'h08, 4'hF, 32'd0, rd);
    bus(BASE, 8'h20, 4'hF, 32'd64, rd);
    bus(BASE, 8'h04, 4'hF, 32'd1, rd);
    bus(BASE, 8'h0C, 4'hF, 32'd1, rd);
    wait_wrap();
    count_period(hi, rises);
    chk("duty64_high", hi, 64);
    chk("duty64_rises", rises, 1);

    // mid-period duty change: current period keeps 64, the next one uses 200
    fork
      count_period(hi, rises);
      begin repeat (100) @(negedge clk_20M); bus(BASE, 8'h20, 4'hF, 32'd200, rd); end
    join
    chk("midwrite_high", hi, 64);
    chk("midwrite_rises", rises, 1);
    count_period(hi, rises);
    chk("duty200_high", hi, 200);
    chk("duty200_rises", rises, 1);

    // interrupt: W1C colliding with a wrap loses; plain W1C clears; irq follows wrap by one edge
    bus(BASE, 8'h0C, 4'hF, 32'd3, rd);
    wait_cnt_max();
    bus(BASE, 8'h10, 4'b0001, 32'd1, rd);
    chk("w1c_at_wrap_irq", 32'(irq_o), 1);
    bus(BASE, 8'h10, 4'b0001, 32'd1, rd);
    chk("w1c_clear_irq", 32'(irq_o), 0);
    wait_cnt_max();
    chk("irq_before_wrap", 32'(irq_o), 0);
    @(negedge clk_20M);
    chk("irq_after_wrap", 32'(irq_o), 1);

    // unmapped / absent channels and held valid
    bus(BASE, 8'h2C, 4'b0000, 32'd0, rd);
    chk("absent_ch_read", rd, 0);
    bus(BASE, 8'h20, 4'b0000, 32'd0, rd);
    chk("duty0_shadow_read", rd, 200);
    iomem_valid = 1'b1; iomem_addr = {BASE, 16'h0, 8'h3C}; iomem_wstrb = '0; pulses = 0;
    repeat (6) begin
      @(negedge clk_20M);
      if (iomem_ready) begin pulses++; chk("held_rdata", iomem_rdata, 0); end
    end
    iomem_valid = 1'b0;
    chk("held_pulses", pulses, 3);

    // randomized traffic; prescale only changes while PWM is disabled
    for (int r = 0; r < 6; r++) begin
      bus(BASE, 8'h0C, 4'hF, 32'd0, rd);
      bus(BASE, 8'h08, 4'hF, 32'($urandom_range(0, 3)), rd);
      bus(BASE, 8'h0C, 4'hF, 32'($urandom_range(0, 3)), rd);
      for (int k = 0; k < 30; k++) begin
        if ($urandom_range(0, 10) == 10) begin
          ix = 6'($urandom_range(0, 63));
          if (ix == 6'd2) ix = 6'd5;
          off = {ix, 2'b00};
        end else begin
          off = offs[$urandom_range(0, 9)];
        end
        ws   = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        base = ($urandom_range(0, 7) == 0) ? 8'h05 : BASE;
        bus(base, off, ws, $urandom, rd);
        repeat ($urandom_range(0, 3)) @(negedge clk_20M);
        if ($urandom_range(0, 9) == 0) repeat ($urandom_range(50, 400)) @(negedge clk_20M);
      end
    end

    // reset in the middle of a high phase
    bus(BASE, 8'h0C, 4'hF, 32'd0, rd);
    bus(BASE, 8'h08, 4'hF, 32'd0, rd);
    bus(BASE, 8'h04, 4'hF, 32'd1, rd);
    bus(BASE, 8'h20, 4'hF, 32'd200, rd);
    bus(BASE, 8'h0C, 4'hF, 32'd3, rd);
    wait_wrap();
    repeat (50) @(negedge clk_20M);
    chk("pre_reset_pin0", 32'(pin_o[0]), 1);
    chk("pre_reset_irq", 32'(irq_o), 1);
    resetn = 1'b0;
    @(negedge clk_20M);
    chk("reset_pin", 32'(pin_o), 0);
    chk("reset_irq", 32'(irq_o), 0);
    resetn = 1'b1;
    @(negedge clk_20M);
    foreach (offs[i]) begin
      bus(BASE, offs[i], 4'b0000, 32'd0, rd);
      chk("post_reset_read", rd, 0);
    end
    bus(BASE, 8'h08, 4'b0000, 32'd0, rd);
    chk("post_reset_prescale", rd, 0);

    repeat (3) @(negedge clk_20M);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
